data_cache: RTL

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/dcache_pkg.sv | 20 ++
 rtl/data_cache_if.sv | 20 ++
 rtl/data_cache_load_align.sv | 26 ++
 rtl/data_cache.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;
  localparam logic [1:0] MODE_NONE = 2'b11;

  localparam int ADDR_W  = 17;
  localparam int OFF_W   = 2;
  localparam int INDEX_W = 6;
  localparam int TAG_W   = ADDR_W - OFF_W - INDEX_W;

endpackage

// File: rtl/data_cache_if.sv
// Backing-memory bus: one outstanding word request, completed by a single-cycle ack.
interface data_cache_if;
  logic        mem_req;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/data_cache_load_align.sv
// Picks the addressed byte/half out of a cached word and sign- or zero-extends it.
module load_align
  import dcache_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  mode,
  input  logic        zext,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = word[{off, 3'b000} +: 8];
    // Halves are taken from the word's upper or lower half; A[0] is ignored.
    h    = off[1] ? word[31:16] : word[15:0];
    data = '0;
    case (mode)
      MODE_BYTE: data = {{24{b[7] & ~zext}}, b};
      MODE_HALF: data = {{16{h[15] & ~zext}}, h};
      MODE_WORD: data = word;
      default:   data = '0;
    endcase
  end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache.
module data_cache
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LINES  = 1 << INDEX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           A,
  input  logic                  RE,
  input  logic                  WE,
  input  logic [2:0]            AddressingControl,
  input  logic [DATA_WIDTH-1:0] WD,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  stall,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  data_cache_if.master          mem
);
  localparam int IDX_B = $clog2(NUM_LINES);
  localparam int TAG_B = ADDR_W - OFF_W - IDX_B;

  state_e state, nxt;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_B-1:0]     tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES];

  logic [IDX_B-1:0] idx;
  logic [TAG_B-1:0] tag;
  logic [1:0]       off, mode;
  logic             hit, done_q, fill_done, wr_done, cnt_hit, cnt_miss;
  logic [31:0]      ld_data, st_wdata;
  logic [3:0]       st_be;
  logic             unused_a;

  assign idx      = A[OFF_W +: IDX_B];
  assign tag      = A[ADDR_W-1 -: TAG_B];
  assign off      = A[1:0];
  assign mode     = AddressingControl[1:0];
  assign hit      = valid[idx] && (tag_mem[idx] == tag);
  assign unused_a = ^A[31:ADDR_W];

  load_align u_align (
    .word (data_mem[idx]),
    .off  (off),
    .mode (mode),
    .zext (AddressingControl[2]),
    .data (ld_data)
  );

  // Store data is replicated across lanes; byte enables select the target lanes.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = WD;
    case (mode)
      MODE_BYTE: begin
        st_be    = 4'b0001 << off;
        st_wdata = {4{WD[7:0]}};
      end
      MODE_HALF: begin
        st_be    = off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{WD[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // done_q marks the cycle after a memory transaction: the held request then
  // completes without a new transaction and without counting as a fresh hit.
  always_comb begin
    nxt           = state;
    stall         = 1'b0;
    RD            = '0;
    cnt_hit       = 1'b0;
    cnt_miss      = 1'b0;
    fill_done     = 1'b0;
    wr_done       = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = {A[ADDR_W-1:2], 2'b00};
    mem.mem_be    = 4'b1111;
    mem.mem_wdata = st_wdata;
    case (state)
      IDLE: begin
        if (WE) begin
          if (mode != MODE_NONE && !done_q) begin
            stall = 1'b1;
            nxt   = WRITE;
          end
        end else if (RE && mode != MODE_NONE) begin
          if (hit) begin
            RD      = ld_data;
            cnt_hit = !done_q;
          end else begin
            stall    = 1'b1;
            cnt_miss = 1'b1;
            nxt      = FILL;
          end
        end
      end
      FILL: begin
        stall       = 1'b1;
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          fill_done = 1'b1;
          nxt       = IDLE;
        end
      end
      WRITE: begin
        stall       = 1'b1;
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        mem.mem_be  = st_be;
        if (mem.mem_ack) begin
          wr_done = 1'b1;
          nxt     = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= '0;
      done_q     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      done_q <= fill_done | wr_done;
      if (fill_done) valid[idx] <= 1'b1;
      if (cnt_hit && hit_count != '1)   hit_count  <= hit_count + 32'd1;
      if (cnt_miss && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= mem.mem_rdata;
    end else if (wr_done && hit) begin
      for (int i = 0; i < 4; i++)
        if (st_be[i]) data_mem[idx][8*i +: 8] <= st_wdata[8*i +: 8];
    end
  end

endmodule
